// File: rtl/param_nonoverlap_clkgen.sv
// -----------------------------------------------------------------------------
// param_nonoverlap_clkgen
//
// Programmable non-overlapping modulation clock generator. CLK_IN is divided by
// a runtime-selectable even period P. CLK_OUT_MOD / CLK_OUT_MODN form a
// complementary pair, offset by P/2, with programmable phase and high time and
// a guaranteed minimum dead time between them. CLK_OUT_MODL is a 50% reference
// at the same period and SYNC marks the cnt==0 output cycle.
//
// Settings are captured into shadow registers on the edge where the counter
// wraps P-1 -> 0, and on the first enabled edge after EN rises or after reset.
// Mid-period changes on the *_SEL inputs therefore never disturb the running
// period.
//
// Ports:
//   CLK_IN        in   1      sole clock, all logic on posedge
//   RST           in   1      synchronous reset, active high
//   EN            in   1      run enable (low: counter parked at 0, outputs 0)
//   PERIOD_SEL    in   CNT_W  period code, P = {PERIOD_SEL[CNT_W-1:1],1'b0}+2
//   PHASE_SEL     in   CNT_W  MOD rising offset in CLK_IN cycles
//   DUTY_SEL      in   CNT_W  requested MOD/MODN high time minus 1
//   DEAD_SEL      in   CNT_W  minimum low gap between MOD and MODN edges
//   CLK_OUT_MOD   out  1      modulation clock
//   CLK_OUT_MODN  out  1      non-overlapping complement, offset P/2
//   CLK_OUT_MODL  out  1      50% reference clock
//   SYNC          out  1      one-cycle pulse on the cnt==0 output cycle
// -----------------------------------------------------------------------------
module param_nonoverlap_clkgen #(
    parameter int CNT_W    = 5,
    parameter int DEF_PER  = 14,
    parameter int DEF_DEAD = 1
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             EN,
    input  logic [CNT_W-1:0] PERIOD_SEL,
    input  logic [CNT_W-1:0] PHASE_SEL,
    input  logic [CNT_W-1:0] DUTY_SEL,
    input  logic [CNT_W-1:0] DEAD_SEL,
    output logic             CLK_OUT_MOD,
    output logic             CLK_OUT_MODN,
    output logic             CLK_OUT_MODL,
    output logic             SYNC
);

    // One extra bit so P (up to 2^CNT_W) and cnt+P never overflow.
    localparam int AW = CNT_W + 1;
    typedef logic [AW-1:0] aw_t;

    localparam aw_t AW_ZERO = aw_t'(1'b0);
    localparam aw_t AW_ONE  = aw_t'(1'b1);
    localparam aw_t AW_TWO  = aw_t'(2'd2);

    localparam logic [CNT_W-1:0] DEF_PER_V  = CNT_W'(DEF_PER);
    localparam logic [CNT_W-1:0] DEF_DEAD_V = CNT_W'(DEF_DEAD);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    // Registers
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] per_q,   per_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] duty_q,  duty_d;
    logic [CNT_W-1:0] dead_q,  dead_d;
    logic             run_q,   run_d;
    logic             mod_q,   mod_d;
    logic             modn_q,  modn_d;
    logic             modl_q,  modl_d;
    logic             sync_q,  sync_d;

    // Working values for the current edge
    logic [CNT_W-1:0] eff_per_s;
    logic [CNT_W-1:0] eff_phase_s;
    logic [CNT_W-1:0] eff_duty_s;
    logic [CNT_W-1:0] eff_dead_s;
    logic [CNT_W-1:0] cnt_eff_s;
    aw_t              p_s;
    aw_t              p_m1_s;
    aw_t              half_s;
    aw_t              ph_s;
    aw_t              duty_p1_s;
    aw_t              room_s;
    aw_t              h_s;
    aw_t              cnt_ext_s;
    aw_t              pos_s;
    aw_t              half_h_s;
    logic             wrap_s;
    logic             load_s;

    // Effective settings and derived timing quantities for this edge.
    // On the first enabled edge the incoming *_SEL values are used directly,
    // so the first output cycle already reflects the freshly loaded settings.
    always_comb begin
        if (run_q) begin
            eff_per_s   = per_q;
            eff_phase_s = phase_q;
            eff_duty_s  = duty_q;
            eff_dead_s  = dead_q;
            cnt_eff_s   = cnt_q;
        end else begin
            eff_per_s   = PERIOD_SEL;
            eff_phase_s = PHASE_SEL;
            eff_duty_s  = DUTY_SEL;
            eff_dead_s  = DEAD_SEL;
            cnt_eff_s   = CNT_ZERO;
        end

        // LSB of the period code is ignored so P is always even.
        p_s    = {1'b0, eff_per_s[CNT_W-1:1], 1'b0} + AW_TWO;
        p_m1_s = p_s - AW_ONE;
        half_s = {1'b0, p_s[AW-1:1]};

        if ({1'b0, eff_phase_s} > p_m1_s) begin
            ph_s = p_m1_s;
        end else begin
            ph_s = {1'b0, eff_phase_s};
        end

        // High time is clipped so HALF-H always leaves at least 'dead' low cycles.
        duty_p1_s = {1'b0, eff_duty_s} + AW_ONE;
        if ({1'b0, eff_dead_s} >= half_s) begin
            room_s = AW_ZERO;
        end else begin
            room_s = half_s - {1'b0, eff_dead_s};
        end
        if (duty_p1_s < room_s) begin
            h_s = duty_p1_s;
        end else begin
            h_s = room_s;
        end

        cnt_ext_s = {1'b0, cnt_eff_s};
        if (cnt_ext_s >= ph_s) begin
            pos_s = cnt_ext_s - ph_s;
        end else begin
            pos_s = cnt_ext_s + p_s - ph_s;
        end

        half_h_s = half_s + h_s;
        wrap_s   = (cnt_ext_s == p_m1_s);
        load_s   = (!run_q) || wrap_s;
    end

    // Next-state: counter, shadow registers and registered outputs.
    always_comb begin
        cnt_d   = cnt_q;
        per_d   = per_q;
        phase_d = phase_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        run_d   = run_q;
        mod_d   = 1'b0;
        modn_d  = 1'b0;
        modl_d  = 1'b0;
        sync_d  = 1'b0;

        if (!EN) begin
            // Parked: counter at 0, outputs low, next enabled edge reloads.
            cnt_d = CNT_ZERO;
            run_d = 1'b0;
        end else begin
            run_d  = 1'b1;
            mod_d  = (pos_s < h_s);
            modn_d = (pos_s >= half_s) && (pos_s < half_h_s);
            modl_d = (cnt_ext_s < half_s);
            sync_d = (cnt_eff_s == CNT_ZERO);

            if (wrap_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_eff_s + CNT_ONE;
            end

            if (load_s) begin
                per_d   = PERIOD_SEL;
                phase_d = PHASE_SEL;
                duty_d  = DUTY_SEL;
                dead_d  = DEAD_SEL;
            end else begin
                per_d   = per_q;
                phase_d = phase_q;
                duty_d  = duty_q;
                dead_d  = dead_q;
            end
        end
    end

    // State registers with synchronous reset to the default shadow settings.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            cnt_q   <= CNT_ZERO;
            per_q   <= DEF_PER_V;
            phase_q <= CNT_ZERO;
            duty_q  <= CNT_ZERO;
            dead_q  <= DEF_DEAD_V;
            run_q   <= 1'b0;
            mod_q   <= 1'b0;
            modn_q  <= 1'b0;
            modl_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            run_q   <= run_d;
            mod_q   <= mod_d;
            modn_q  <= modn_d;
            modl_q  <= modl_d;
            sync_q  <= sync_d;
        end
    end

    assign CLK_OUT_MOD  = mod_q;
    assign CLK_OUT_MODN = modn_q;
    assign CLK_OUT_MODL = modl_q;
    assign SYNC         = sync_q;

endmodule

// File: tb/tb_param_nonoverlap_clkgen.sv
// -----------------------------------------------------------------------------
// Self-checking bench for param_nonoverlap_clkgen. A cycle-level reference
// model computes the expected outputs from the period/phase/duty/dead rules
// with plain integer arithmetic; directed scenarios are followed by a
// randomized run that also checks the no-overlap and dead-time invariants.
// -----------------------------------------------------------------------------
module tb_param_nonoverlap_clkgen;

    localparam int CNT_W    = 5;
    localparam int DEF_PER  = 14;
    localparam int DEF_DEAD = 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] per_sel;
    logic [CNT_W-1:0] phase_sel;
    logic [CNT_W-1:0] duty_sel;
    logic [CNT_W-1:0] dead_sel;
    logic             mod_o;
    logic             modn_o;
    logic             modl_o;
    logic             sync_o;

    param_nonoverlap_clkgen #(
        .CNT_W   (CNT_W),
        .DEF_PER (DEF_PER),
        .DEF_DEAD(DEF_DEAD)
    ) dut (
        .CLK_IN      (clk),
        .RST         (rst),
        .EN          (en),
        .PERIOD_SEL  (per_sel),
        .PHASE_SEL   (phase_sel),
        .DUTY_SEL    (duty_sel),
        .DEAD_SEL    (dead_sel),
        .CLK_OUT_MOD (mod_o),
        .CLK_OUT_MODN(modn_o),
        .CLK_OUT_MODL(modl_o),
        .SYNC        (sync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int m_cnt, m_run, m_per, m_phase, m_duty, m_dead;
    logic e_mod, e_modn, e_modl, e_sync;

    // Invariant tracking / counting
    bit gap_en = 1'b0;
    int last_mod_hi = -1;
    int last_modn_hi = -1;
    logic prev_mod = 1'b0;
    logic prev_modn = 1'b0;
    int n_mod, n_modn, n_modl, n_sync;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic load_shadow();
        m_per   = int'(per_sel);
        m_phase = int'(phase_sel);
        m_duty  = int'(duty_sel);
        m_dead  = int'(dead_sel);
    endtask

    // Advance the reference model by one CLK_IN edge using the sampled inputs.
    task automatic model_step();
        int p, half, ph, h, pos;
        if (rst) begin
            m_cnt = 0; m_run = 0;
            m_per = DEF_PER; m_phase = 0; m_duty = 0; m_dead = DEF_DEAD;
            e_mod = 1'b0; e_modn = 1'b0; e_modl = 1'b0; e_sync = 1'b0;
        end else if (!en) begin
            m_cnt = 0; m_run = 0;
            e_mod = 1'b0; e_modn = 1'b0; e_modl = 1'b0; e_sync = 1'b0;
        end else begin
            if (m_run == 0) begin
                load_shadow();
                m_cnt = 0;
            end
            p    = (m_per / 2) * 2 + 2;
            half = p / 2;
            ph   = (m_phase < p - 1) ? m_phase : p - 1;
            h    = m_duty + 1;
            if (half - m_dead < h) h = half - m_dead;
            if (h < 0) h = 0;
            pos  = (m_cnt - ph + p) % p;
            e_mod  = (pos < h);
            e_modn = (pos >= half) && (pos < half + h);
            e_modl = (m_cnt < half);
            e_sync = (m_cnt == 0);
            if (m_cnt == p - 1) begin
                m_cnt = 0;
                load_shadow();
            end else begin
                m_cnt++;
            end
            m_run = 1;
        end
    endtask

    // One clock: model update at the edge, DUT compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("mod",  mod_o,  e_mod);
        chk("modn", modn_o, e_modn);
        chk("modl", modl_o, e_modl);
        chk("sync", sync_o, e_sync);
        chk("overlap", mod_o & modn_o, 1'b0);
        n_mod  += int'(mod_o);
        n_modn += int'(modn_o);
        n_modl += int'(modl_o);
        n_sync += int'(sync_o);
        if (m_run == 0 || !gap_en) begin
            last_mod_hi  = -1;
            last_modn_hi = -1;
        end else begin
            if (mod_o && !prev_mod && last_modn_hi >= 0)
                chk("dead_modn_to_mod", (cyc - last_modn_hi - 1 >= m_dead), 1'b1);
            if (modn_o && !prev_modn && last_mod_hi >= 0)
                chk("dead_mod_to_modn", (cyc - last_mod_hi - 1 >= m_dead), 1'b1);
            if (mod_o)  last_mod_hi  = cyc;
            if (modn_o) last_modn_hi = cyc;
        end
        prev_mod  = mod_o;
        prev_modn = modn_o;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_counts();
        n_mod = 0; n_modn = 0; n_modl = 0; n_sync = 0;
    endtask

    task automatic run_until_cnt(input int target);
        for (int i = 0; i < 64 && m_cnt != target; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        per_sel = 5'd14; phase_sel = 5'd0; duty_sel = 5'd7; dead_sel = 5'd1;
        clear_counts();

        // Reset state
        run(2);
        rst = 1'b0;
        chk("reset_mod", mod_o, 1'b0);
        chk("reset_sync", sync_o, 1'b0);

        // T1: defaults, two full periods
        en = 1'b1;
        clear_counts();
        run(32);
        chk_int("t1_mod_count",  n_mod,  14);
        chk_int("t1_modn_count", n_modn, 14);
        chk_int("t1_modl_count", n_modl, 16);
        chk_int("t1_sync_count", n_sync, 2);

        // T2: phase change mid-period takes effect next period
        run_until_cnt(5);
        phase_sel = 5'd3;
        run(40);

        // T3: odd period code, then P=32 with clipped duty
        phase_sel = 5'd0; per_sel = 5'd15;
        run(40);
        per_sel = 5'd31; duty_sel = 5'd31; dead_sel = 5'd2;
        run(70);

        // T4: dead >= HALF keeps MOD/MODN low
        per_sel = 5'd14; duty_sel = 5'd7; dead_sel = 5'd8;
        run(40);
        clear_counts();
        run(32);
        chk_int("t4_mod_count",  n_mod,  0);
        chk_int("t4_modn_count", n_modn, 0);
        chk_int("t4_modl_count", n_modl, 16);

        // T5: reset at cnt 9, restart with defaults-like timing
        dead_sel = 5'd1;
        run(20);
        run_until_cnt(9);
        rst = 1'b1;
        cycle();
        chk("t5_rst_modl", modl_o, 1'b0);
        rst = 1'b0;
        run(40);

        // T6: EN low for 5 cycles mid-period, new settings on resume
        run_until_cnt(5);
        en = 1'b0;
        run(5);
        per_sel = 5'd10; phase_sel = 5'd2; duty_sel = 5'd3; dead_sel = 5'd1;
        en = 1'b1;
        cycle();
        chk("t6_first_sync", sync_o, 1'b1);
        run(30);

        // Random settings; changes only while EN is low so each run is stable
        gap_en = 1'b1;
        for (int seg = 0; seg < 300; seg++) begin
            en = 1'b0;
            per_sel   = 5'($urandom_range(0, 31));
            phase_sel = 5'($urandom_range(0, 31));
            duty_sel  = 5'($urandom_range(0, 31));
            dead_sel  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 4));
            run(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            en = 1'b1;
            run(int'($urandom_range(20, 80)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
